led_pwm_matrix: RTL and testbench
=================================

LED_PWM_MATRIX -- requirements
Module: led_pwm_matrix

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'h50000000, meaning the reset value of the base-address register.
REQ-002 SHALL have parameter ROWS, default 12, meaning the number of multiplexed rows (1..16).
REQ-003 SHALL have parameter COLUMNS, default 10, meaning the number of columns per row (1..16).
REQ-004 SHALL have parameter PWM_BITS, default 4, meaning per-colour intensity width (1..8).
REQ-005 SHALL have port clock  input  1  single system clock; all logic is on the rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-007 SHALL have ports beginTransactionIn, endTransactionIn, readNotWriteIn, dataValidIn, busyIn, busErrorIn  input  1 each  bus control.
REQ-008 SHALL have ports addressDataIn  input  32, byteEnablesIn  input  4, burstSizeIn  input  8  bus address/data and qualifiers.
REQ-009 SHALL have ports endTransactionOut, dataValidOut, busErrorOut  output  1 each, and addressDataOut  output  32  bus responses.
REQ-010 SHALL have port scanTickIn  input  1  single-cycle PWM step strobe.
REQ-011 SHALL have ports rowSelect  output  4, and nRed, nGreen, nBlue  output  COLUMNS each  active-low column drives.

Function
REQ-012 SHALL register all bus inputs one cycle; a transaction is the block's if it is active and the registered address bits [31:12] equal base-address register bits [31:12].
REQ-013 SHALL derive the word index from address bits [11:2]: pixel p = row*COLUMNS+col at index p; 0x3FE = base-address register; 0x3FF = control register.
REQ-014 SHALL hold pixel data as {R,G,B}, each PWM_BITS wide, in data bits [3*PWM_BITS-1:0]; higher read bits are 0.
REQ-015 SHALL define control bit0 = display enable (reset 0) and bit1 = gamma-invert (reset 0; when 1 the compared intensity is the bitwise inverse of the stored value).
REQ-016 SHALL, on writes, store each registered dataValidIn word at the current index and increment the index by 1 (burst).
REQ-017 SHALL ignore writes to indices >= ROWS*COLUMNS other than 0x3FE/0x3FF; reads of them return 0.
REQ-018 SHALL, on reads, return burstSizeIn+1 words, starting with dataValidOut high in the third cycle after beginTransactionIn; the index advances only when busyIn is low.
REQ-019 SHALL hold addressDataOut and dataValidOut stable while busyIn is high; addressDataOut SHALL be 0 whenever dataValidOut is low.
REQ-020 SHALL pulse endTransactionOut for exactly one cycle after the last read word is accepted (busyIn low).
REQ-021 SHALL assert busErrorOut while the transaction is the block's and byteEnables != 4'hF; the transaction then performs no writes, and busErrorOut clears on endTransactionIn.
REQ-022 SHALL abort any read burst immediately on busErrorIn, forcing dataValidOut low next cycle with no endTransactionOut.
REQ-023 SHALL keep a PWM_BITS counter that increments on each scanTickIn; on wrap from all-ones to 0, rowSelect advances to the next row: ROWS-1 down to 0, then ROWS-1.
REQ-024 SHALL register the column drives: nX[c] = ~(enable & (intensityX[rowSelect][c] > counter)); intensity 0 is always off, and all-ones is on for 2^PWM_BITS-1 of 2^PWM_BITS steps.
REQ-025 SHALL apply a pixel write to the display from the next scan step; a write that coincides with scanTickIn SHALL not corrupt the counter.

Reset
REQ-026 SHALL, while reset=0, clear all pixels and control, load base address = BASE_ADDRESS, set counter = 0 and rowSelect = ROWS-1, drive nRed/nGreen/nBlue all ones, and drive dataValidOut, endTransactionOut and busErrorOut = 0 with addressDataOut = 0.
REQ-027 SHALL, when reset occurs mid-transaction, abandon the transaction without producing a response.

Verification
REQ-028 Write 0x00000FFF to index 0 (PWM_BITS=4), enable=1 -> column 0 of row 0 low for 15 of 16 ticks, high on the tick with counter=15.
REQ-029 Burst write of 4 words starting at index 5, then burst read with burstSize=3 -> the same 4 words returned in order, with one endTransactionOut pulse.
REQ-030 Read burst with busyIn held high for 3 cycles on word 2 -> word 2 is held; no word is skipped or duplicated.
REQ-031 Write with byteEnables=4'h3 -> busErrorOut=1, pixel unchanged, busErrorOut=0 after endTransactionIn.
REQ-032 Write 0x60000000 to index 0x3FE, then access 0x60000000 -> the block responds; 0x50000000 is ignored.
REQ-033 Reset asserted during a read burst -> dataValidOut=0 next cycle, rowSelect=ROWS-1, all column drives high.

Source files
------------

// File: rtl/led_pwm_matrix_if.sv
// led_pwm_matrix_if -- bus bundle for the LED PWM matrix.
//   slave  : the matrix. It receives begin/end/readNotWrite/dataValid/busy/busError,
//            addressData, byteEnables and burstSize, and it drives endTransaction,
//            dataValid, busError and addressData back.
//   master : the bus side, with every direction reversed.
`timescale 1ns/1ps
interface led_pwm_matrix_if;
  logic        beginTransactionIn;
  logic        endTransactionIn;
  logic        readNotWriteIn;
  logic        dataValidIn;
  logic        busyIn;
  logic        busErrorIn;
  logic [31:0] addressDataIn;
  logic [3:0]  byteEnablesIn;
  logic [7:0]  burstSizeIn;
  logic        endTransactionOut;
  logic        dataValidOut;
  logic        busErrorOut;
  logic [31:0] addressDataOut;

  modport slave (
    input  beginTransactionIn, endTransactionIn, readNotWriteIn, dataValidIn,
           busyIn, busErrorIn, addressDataIn, byteEnablesIn, burstSizeIn,
    output endTransactionOut, dataValidOut, busErrorOut, addressDataOut
  );

  modport master (
    output beginTransactionIn, endTransactionIn, readNotWriteIn, dataValidIn,
           busyIn, busErrorIn, addressDataIn, byteEnablesIn, burstSizeIn,
    input  endTransactionOut, dataValidOut, busErrorOut, addressDataOut
  );
endinterface

// File: rtl/led_pwm_matrix.sv
// led_pwm_matrix -- a bus-mapped RGB LED matrix with row multiplexing and PWM.
// The matrix occupies one 4 KB window. Within that window:
//   - word p holds pixel p = row*COLUMNS+col as {R,G,B},
//   - word 0x3FE holds the base address of the window,
//   - word 0x3FF is control: bit0 enables the display, bit1 inverts the
//     intensities before they are compared with the counter.
// Ports:
//   clock, reset  rising-edge clock and synchronous active-low reset
//   bus           slave side of led_pwm_matrix_if (burst reads and writes)
//   scanTickIn    one-cycle PWM step strobe
//   rowSelect     the row being driven
//   nRed/nGreen/nBlue  registered active-low column drives
`timescale 1ns/1ps
module led_pwm_matrix #(
  parameter logic [31:0] BASE_ADDRESS = 32'h50000000,
  parameter int          ROWS         = 12,
  parameter int          COLUMNS      = 10,
  parameter int          PWM_BITS     = 4
) (
  input  logic               clock,
  input  logic               reset,
  led_pwm_matrix_if.slave    bus,
  input  logic               scanTickIn,
  output logic [3:0]         rowSelect,
  output logic [COLUMNS-1:0] nRed,
  output logic [COLUMNS-1:0] nGreen,
  output logic [COLUMNS-1:0] nBlue
);
  localparam int NPIX = ROWS * COLUMNS;
  localparam int PW   = 3 * PWM_BITS;
  localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_ERROR} state_t;

  // registered bus inputs (busy/busError are used directly so that the
  // hold and the abort take effect on the very next edge)
  logic        begin_q, end_q, rnw_q, dv_q;
  logic [31:0] ad_q;
  logic [3:0]  be_q;
  logic [7:0]  burst_q;

  state_t      state_q, state_d;
  logic [9:0]  idx_q, idx_d;
  logic [7:0]  remain_q, remain_d;
  logic        dvo_q, dvo_d, eto_q, eto_d, berr_q, berr_d;
  logic [31:0] ado_q, ado_d;
  logic        we;
  logic [31:0] rd_word;
  logic        hit;

  logic [31:0] base_q;
  logic [1:0]  ctrl_q;
  logic [PW-1:0] pix_q [NPIX];

  logic [PWM_BITS-1:0] cnt_q;
  logic [3:0]          row_q;
  logic [COLUMNS-1:0]  nr_q, ng_q, nb_q, nr_d, ng_d, nb_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      begin_q <= 1'b0;
      end_q   <= 1'b0;
      rnw_q   <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      begin_q <= bus.beginTransactionIn;
      end_q   <= bus.endTransactionIn;
      rnw_q   <= bus.readNotWriteIn;
      dv_q    <= bus.dataValidIn;
    end
  end

  always_ff @(posedge clock) begin
    ad_q    <= bus.addressDataIn;
    be_q    <= bus.byteEnablesIn;
    burst_q <= bus.burstSizeIn;
  end

  assign hit = begin_q && (ad_q[31:12] == base_q[31:12]);

  always_comb begin
    rd_word = '0;
    if (idx_q == 10'h3FE)      rd_word = base_q;
    else if (idx_q == 10'h3FF) rd_word = {30'd0, ctrl_q};
    else if (int'(idx_q) < NPIX) rd_word[PW-1:0] = pix_q[idx_q[IW-1:0]];
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    remain_d = remain_q;
    dvo_d    = dvo_q;
    ado_d    = ado_q;
    eto_d    = 1'b0;
    berr_d   = berr_q;
    we       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          idx_d    = ad_q[11:2];
          remain_d = burst_q;
          if (be_q != 4'hF) begin
            berr_d  = 1'b1;
            state_d = S_ERROR;
          end else if (rnw_q) begin
            state_d = S_READ;
          end else begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (dv_q) begin
          we    = 1'b1;
          idx_d = idx_q + 10'd1;
        end
        if (end_q) state_d = S_IDLE;
      end
      S_READ: begin
        if (bus.busErrorIn) begin
          // the abort drops the word on the bus and sends no end pulse
          dvo_d   = 1'b0;
          ado_d   = '0;
          state_d = S_IDLE;
        end else if (!dvo_q) begin
          dvo_d = 1'b1;
          ado_d = rd_word;
          idx_d = idx_q + 10'd1;
        end else if (!bus.busyIn) begin
          if (remain_q == 8'd0) begin
            dvo_d   = 1'b0;
            ado_d   = '0;
            eto_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            ado_d    = rd_word;
            idx_d    = idx_q + 10'd1;
            remain_d = remain_q - 8'd1;
          end
        end
      end
      S_ERROR: begin
        if (end_q) begin
          berr_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      remain_q <= '0;
      dvo_q    <= 1'b0;
      ado_q    <= '0;
      eto_q    <= 1'b0;
      berr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      remain_q <= remain_d;
      dvo_q    <= dvo_d;
      ado_q    <= ado_d;
      eto_q    <= eto_d;
      berr_q   <= berr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      base_q <= BASE_ADDRESS;
      ctrl_q <= 2'b00;
      for (int i = 0; i < NPIX; i++) pix_q[i] <= '0;
    end else if (we) begin
      if (idx_q == 10'h3FE)        base_q <= ad_q;
      else if (idx_q == 10'h3FF)   ctrl_q <= ad_q[1:0];
      else if (int'(idx_q) < NPIX) pix_q[idx_q[IW-1:0]] <= ad_q[PW-1:0];
    end
  end

  // Column drives for the current row and counter; they are registered
  // below, so a pixel write shows up on the next scan step.
  always_comb begin
    logic [IW-1:0]       pi;
    logic [PW-1:0]       px;
    logic [PWM_BITS-1:0] ir, ig, ib;
    nr_d = '1;
    ng_d = '1;
    nb_d = '1;
    for (int c = 0; c < COLUMNS; c++) begin
      pi = IW'(int'(row_q) * COLUMNS + c);
      px = pix_q[pi];
      ir = px[3*PWM_BITS-1 -: PWM_BITS];
      ig = px[2*PWM_BITS-1 -: PWM_BITS];
      ib = px[PWM_BITS-1:0];
      if (ctrl_q[1]) begin
        ir = ~ir;
        ig = ~ig;
        ib = ~ib;
      end
      nr_d[c] = ~(ctrl_q[0] & (ir > cnt_q));
      ng_d[c] = ~(ctrl_q[0] & (ig > cnt_q));
      nb_d[c] = ~(ctrl_q[0] & (ib > cnt_q));
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
      row_q <= 4'(ROWS - 1);
      nr_q  <= '1;
      ng_q  <= '1;
      nb_q  <= '1;
    end else begin
      if (scanTickIn) begin
        cnt_q <= cnt_q + PWM_BITS'(1);
        // the row moves on when the counter wraps; rows are scanned downwards
        if (cnt_q == '1) row_q <= (row_q == 4'd0) ? 4'(ROWS - 1) : row_q - 4'd1;
      end
      nr_q <= nr_d;
      ng_q <= ng_d;
      nb_q <= nb_d;
    end
  end

  assign bus.endTransactionOut = eto_q;
  assign bus.dataValidOut      = dvo_q;
  assign bus.busErrorOut       = berr_q;
  assign bus.addressDataOut    = ado_q;
  assign rowSelect             = row_q;
  assign nRed                  = nr_q;
  assign nGreen                = ng_q;
  assign nBlue                 = nb_q;
endmodule

// File: tb/tb_led_pwm_matrix.sv
`timescale 1ns/1ps
module tb_led_pwm_matrix;
  localparam int ROWS = 12;
  localparam int COLUMNS = 10;
  localparam int PWM_BITS = 4;
  localparam int NPIX = ROWS * COLUMNS;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic scanTickIn = 1'b0;
  logic [3:0] rowSelect;
  logic [COLUMNS-1:0] nRed, nGreen, nBlue;

  led_pwm_matrix_if bus();

  led_pwm_matrix #(
    .BASE_ADDRESS(32'h50000000), .ROWS(ROWS), .COLUMNS(COLUMNS), .PWM_BITS(PWM_BITS)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus), .scanTickIn(scanTickIn),
    .rowSelect(rowSelect), .nRed(nRed), .nGreen(nGreen), .nBlue(nBlue)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic [31:0] expq[$];
  logic [11:0] mpix [NPIX];
  logic [31:0] mbase;
  logic [1:0]  mctrl;
  int          mcnt, mrow;
  logic [31:0] wbuf [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] mword(input int idx);
    if (idx == 1022) return mbase;
    if (idx == 1023) return {30'd0, mctrl};
    if (idx < NPIX) return {20'd0, mpix[idx]};
    return 32'd0;
  endfunction

  function automatic void adv();
    if (mcnt == 15) begin
      mcnt = 0;
      mrow = (mrow == 0) ? ROWS - 1 : mrow - 1;
    end else mcnt++;
  endfunction

  function automatic logic [COLUMNS-1:0] mdrive(input int colour);
    logic [COLUMNS-1:0] r;
    logic [3:0] v;
    for (int c = 0; c < COLUMNS; c++) begin
      v = mpix[mrow*COLUMNS + c][(2-colour)*4 +: 4];
      if (mctrl[1]) v = ~v;
      r[c] = !(mctrl[0] && (v > 4'(mcnt)));
    end
    return r;
  endfunction

  task automatic pwm_cmp(input string tag);
    @(negedge clock);
    chk({tag, " rowSelect"}, 32'(rowSelect), 32'(mrow));
    chk({tag, " nRed"}, 32'(nRed), 32'(mdrive(0)));
    chk({tag, " nGreen"}, 32'(nGreen), 32'(mdrive(1)));
    chk({tag, " nBlue"}, 32'(nBlue), 32'(mdrive(2)));
  endtask

  task automatic scan_tick(input string tag);
    scanTickIn = 1'b1;
    step();
    scanTickIn = 1'b0;
    adv();
    step();
    pwm_cmp(tag);
  endtask

  task automatic bus_write(input logic [31:0] addr, input int n, input logic [3:0] be,
                           input bit tick_first);
    int idx;
    bit hit;
    hit = (addr[31:12] == mbase[31:12]);
    idx = int'(addr[11:2]);
    bus.beginTransactionIn = 1'b1;
    bus.readNotWriteIn = 1'b0;
    bus.addressDataIn = addr;
    bus.byteEnablesIn = be;
    step();
    bus.beginTransactionIn = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.addressDataIn = wbuf[i];
      bus.dataValidIn = 1'b1;
      scanTickIn = tick_first && (i == 0);
      step();
      if (scanTickIn) adv();
      scanTickIn = 1'b0;
      if (hit && be == 4'hF) begin
        if (idx < NPIX) mpix[idx] = wbuf[i][11:0];
        else if (idx == 1022) mbase = wbuf[i];
        else if (idx == 1023) mctrl = wbuf[i][1:0];
      end
      idx++;
    end
    bus.dataValidIn = 1'b0;
    bus.addressDataIn = '0;
    bus.byteEnablesIn = 4'hF;
    bus.endTransactionIn = 1'b1;
    step();
    bus.endTransactionIn = 1'b0;
    step();
    step();
  endtask

  task automatic bus_read(input logic [31:0] addr, input int burst, input int busy_at,
                          input int busy_len, input bit expect_resp, input string tag);
    int first, acc, eto_cnt, eto_k, last_k, busy_left;
    bit holding;
    logic [31:0] held;
    first = -1; acc = 0; eto_cnt = 0; eto_k = -1; last_k = -1;
    busy_left = busy_len; holding = 1'b0; held = '0;
    if (expect_resp)
      for (int i = 0; i <= burst; i++) expq.push_back(mword(int'(addr[11:2]) + i));
    bus.beginTransactionIn = 1'b1;
    bus.readNotWriteIn = 1'b1;
    bus.addressDataIn = addr;
    bus.burstSizeIn = 8'(burst);
    bus.byteEnablesIn = 4'hF;
    step();
    bus.beginTransactionIn = 1'b0;
    bus.readNotWriteIn = 1'b0;
    bus.addressDataIn = '0;
    for (int k = 1; k <= 60; k++) begin
      bus.busyIn = bus.dataValidOut && (acc == busy_at) && (busy_left > 0);
      if (bus.busyIn) busy_left--;
      @(negedge clock);
      if (holding) begin
        chk({tag, " held data"}, bus.addressDataOut, held);
        chk({tag, " held valid"}, 32'(bus.dataValidOut), 32'd1);
        holding = 1'b0;
      end
      if (bus.dataValidOut && first < 0) first = k;
      if (!bus.dataValidOut) chk({tag, " idle data"}, bus.addressDataOut, 32'd0);
      else if (bus.busyIn) begin
        holding = 1'b1;
        held = bus.addressDataOut;
      end else begin
        acc++;
        last_k = k;
        if (expq.size() == 0) chk({tag, " extra word"}, 32'(acc), 32'(burst + 1));
        else chk({tag, " word"}, bus.addressDataOut, expq.pop_front());
      end
      if (bus.endTransactionOut) begin
        eto_cnt++;
        if (eto_k < 0) eto_k = k;
      end
      if (expect_resp && eto_k >= 0 && k >= eto_k + 3) break;
      if (!expect_resp && k >= 12) break;
      step();
    end
    bus.busyIn = 1'b0;
    if (expect_resp) begin
      chk({tag, " first valid cycle"}, 32'(first), 32'd3);
      chk({tag, " word count"}, 32'(acc), 32'(burst + 1));
      chk({tag, " end pulses"}, 32'(eto_cnt), 32'd1);
      chk({tag, " end timing"}, 32'(eto_k), 32'(last_k + 1));
      chk({tag, " words left"}, 32'(expq.size()), 32'd0);
      expq.delete();
    end else begin
      chk({tag, " no valid"}, 32'(first), 32'hFFFF_FFFF);
      chk({tag, " no end"}, 32'(eto_cnt), 32'd0);
    end
    step();
  endtask

  task automatic rd_start(input logic [31:0] addr, input int burst, output bit found);
    found = 1'b0;
    bus.beginTransactionIn = 1'b1;
    bus.readNotWriteIn = 1'b1;
    bus.addressDataIn = addr;
    bus.burstSizeIn = 8'(burst);
    step();
    bus.beginTransactionIn = 1'b0;
    bus.readNotWriteIn = 1'b0;
    bus.addressDataIn = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (bus.dataValidOut) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit found;
    int low0, ecnt, vcnt, pidx;
    bus.beginTransactionIn = 1'b0; bus.endTransactionIn = 1'b0;
    bus.readNotWriteIn = 1'b0; bus.dataValidIn = 1'b0; bus.busyIn = 1'b0;
    bus.busErrorIn = 1'b0; bus.addressDataIn = '0; bus.byteEnablesIn = 4'hF;
    bus.burstSizeIn = '0;
    for (int i = 0; i < NPIX; i++) mpix[i] = '0;
    mbase = 32'h50000000; mctrl = 2'b00; mcnt = 0; mrow = ROWS - 1;

    // reset state
    repeat (3) step();
    @(negedge clock);
    chk("rst dataValidOut", 32'(bus.dataValidOut), 32'd0);
    chk("rst endTransactionOut", 32'(bus.endTransactionOut), 32'd0);
    chk("rst busErrorOut", 32'(bus.busErrorOut), 32'd0);
    chk("rst addressDataOut", bus.addressDataOut, 32'd0);
    chk("rst rowSelect", 32'(rowSelect), 32'(ROWS - 1));
    chk("rst nRed", 32'(nRed), 32'h3FF);
    chk("rst nGreen", 32'(nGreen), 32'h3FF);
    chk("rst nBlue", 32'(nBlue), 32'h3FF);
    step();
    reset = 1'b1;
    step();

    bus_read(32'h50000FFC, 0, -1, 0, 1'b1, "ctrl read");
    bus_read(32'h50000FF8, 0, -1, 0, 1'b1, "base read");

    // burst write four words at index 5, read them back
    wbuf[0] = 32'h00000ABC; wbuf[1] = 32'h00000123;
    wbuf[2] = 32'hFFFFF456; wbuf[3] = 32'h00000789;
    bus_write(32'h50000014, 4, 4'hF, 1'b0);
    bus_read(32'h50000014, 3, -1, 0, 1'b1, "burst read");
    bus_read(32'h50000014, 3, 2, 3, 1'b1, "busy read");

    // index outside the pixel array
    wbuf[0] = 32'h00000ABC;
    bus_write(32'h50000320, 1, 4'hF, 1'b0);
    bus_read(32'h50000320, 0, -1, 0, 1'b1, "out of range");

    // bad byte enables
    bus.beginTransactionIn = 1'b1; bus.addressDataIn = 32'h50000014; bus.byteEnablesIn = 4'h3;
    step();
    bus.beginTransactionIn = 1'b0; bus.addressDataIn = 32'h0; bus.dataValidIn = 1'b1;
    step();
    bus.dataValidIn = 1'b0;
    @(negedge clock);
    chk("bus error set", 32'(bus.busErrorOut), 32'd1);
    bus.endTransactionIn = 1'b1;
    step();
    bus.endTransactionIn = 1'b0; bus.byteEnablesIn = 4'hF;
    step(); step();
    @(negedge clock);
    chk("bus error cleared", 32'(bus.busErrorOut), 32'd0);
    bus_read(32'h50000014, 0, -1, 0, 1'b1, "pixel after error");

    // relocate the window
    wbuf[0] = 32'h60000000;
    bus_write(32'h50000FF8, 1, 4'hF, 1'b0);
    bus_read(32'h50000014, 0, -1, 0, 1'b0, "old base ignored");
    bus_read(32'h60000014, 3, -1, 0, 1'b1, "new base read");

    // full-intensity pixel 0 with the display on
    wbuf[0] = 32'h00000FFF;
    bus_write(32'h60000000, 1, 4'hF, 1'b0);
    wbuf[0] = 32'h00000001;
    bus_write(32'h60000FFC, 1, 4'hF, 1'b0);
    pwm_cmp("pwm start");
    low0 = 0;
    for (int t = 0; t < 16 * ROWS; t++) begin
      scan_tick("pwm");
      if (rowSelect == 4'd0 && nRed[0] == 1'b0) low0++;
    end
    chk("row0 col0 on steps", 32'(low0), 32'd15);

    // gamma invert, then a pixel write on the same cycle as a scan tick
    wbuf[0] = 32'h00000003;
    bus_write(32'h60000FFC, 1, 4'hF, 1'b0);
    for (int t = 0; t < 20; t++) scan_tick("gamma");
    pidx = mrow * COLUMNS + 3;
    wbuf[0] = 32'h000008F0;
    bus_write(32'h60000000 | 32'(pidx * 4), 1, 4'hF, 1'b1);
    pwm_cmp("tick with write");
    for (int t = 0; t < 20; t++) scan_tick("after write");

    // abort a read burst with busErrorIn
    rd_start(32'h60000014, 3, found);
    chk("abort started", 32'(found), 32'd1);
    bus.busErrorIn = 1'b1;
    step();
    bus.busErrorIn = 1'b0;
    @(negedge clock);
    chk("abort valid low", 32'(bus.dataValidOut), 32'd0);
    chk("abort data zero", bus.addressDataOut, 32'd0);
    ecnt = 0; vcnt = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      @(negedge clock);
      if (bus.endTransactionOut) ecnt++;
      if (bus.dataValidOut) vcnt++;
    end
    chk("abort no end", 32'(ecnt), 32'd0);
    chk("abort stays idle", 32'(vcnt), 32'd0);

    // reset in the middle of a read burst
    rd_start(32'h60000014, 3, found);
    chk("reset read started", 32'(found), 32'd1);
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int i = 0; i < NPIX; i++) mpix[i] = '0;
    mbase = 32'h50000000; mctrl = 2'b00; mcnt = 0; mrow = ROWS - 1;
    @(negedge clock);
    chk("mid reset valid", 32'(bus.dataValidOut), 32'd0);
    chk("mid reset rowSelect", 32'(rowSelect), 32'(ROWS - 1));
    chk("mid reset nRed", 32'(nRed), 32'h3FF);
    chk("mid reset nGreen", 32'(nGreen), 32'h3FF);
    chk("mid reset nBlue", 32'(nBlue), 32'h3FF);
    ecnt = 0; vcnt = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      @(negedge clock);
      if (bus.endTransactionOut) ecnt++;
      if (bus.dataValidOut) vcnt++;
    end
    chk("mid reset no end", 32'(ecnt), 32'd0);
    chk("mid reset no data", 32'(vcnt), 32'd0);
    step();
    bus_read(32'h50000FF8, 0, -1, 0, 1'b1, "base after reset");
    bus_read(32'h50000014, 0, -1, 0, 1'b1, "pixel after reset");
    pwm_cmp("pwm after reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
